// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiply / multiply-accumulate unit
// for the single-cycle ARM core. Executes MUL (rd = rm*rs) and MLA
// (rd = rm*rs + rn). It retires one multiplier bit per clock and stalls the
// core while it iterates.
//
// Optional build macro: MUL_EARLY_TERM_EN
//   defined   - the iteration ends as soon as the remaining multiplier bits
//               are all zero, so latency = max(1, msb_index(rs)+1) edges
//   undefined - always W iterations (fixed latency)
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   reset      synchronous, active-high reset
//   start      issue request, sampled only in IDLE
//   accumulate 1 = MLA (acc starts at rn_val), 0 = MUL
//   rm_val     multiplicand (register-file RD1)
//   rs_val     multiplier (register-file RD2)
//   rn_val     accumulator operand, ignored for MUL
//   rd_addr    destination register index
//   stall      combinational hold request to the core
//   busy       high in RUN and WB
//   done       one-cycle completion pulse (the WB cycle)
//   wb_we      register-file write enable (never for rd = r15)
//   wb_addr    register-file write address
//   wb_data    register-file write data
//   flag_n     result bit W-1, valid with done
//   flag_z     result == 0, valid with done
module mul_unit #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         accumulate,
  input  logic [W-1:0] rm_val,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rn_val,
  input  logic [3:0]   rd_addr,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic         wb_we,
  output logic [3:0]   wb_addr,
  output logic [W-1:0] wb_data,
  output logic         flag_n,
  output logic         flag_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  mcand_reg;
  logic [W-1:0]  mplier_reg;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] count_reg;
  logic [3:0]    rd_reg;

  logic [W-1:0]  acc_next;
  logic          last_iter;
  logic          in_wb;

  // Partial product for this iteration: add the shifted multiplicand when
  // the current multiplier LSB is set. Wraps mod 2^W by construction.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : {W{1'b0}});

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this step; the remaining
  // iterations would only add zero.
  assign last_iter = (mplier_reg[W-1:1] == {(W-1){1'b0}}) ||
                     (count_reg == CW'(W-1));
`else
  assign last_iter = (count_reg == CW'(W-1));
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_iter) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      rd_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= rm_val;
            mplier_reg <= rs_val;
            acc_reg    <= accumulate ? rn_val : {W{1'b0}};
            count_reg  <= '0;
            rd_reg     <= rd_addr;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so they read zero outside WB and are
  // cleared by reset along with the FSM.
  assign in_wb   = (state_reg == WB);
  assign stall   = ((state_reg == IDLE) && start) || (state_reg == RUN);
  assign busy    = (state_reg == RUN) || in_wb;
  assign done    = in_wb;
  // r15 as destination is illegal for MUL: run to completion, suppress write.
  assign wb_we   = in_wb && (rd_reg != 4'hF);
  assign wb_addr = in_wb ? rd_reg : 4'h0;
  assign wb_data = in_wb ? acc_reg : {W{1'b0}};
  assign flag_n  = in_wb && acc_reg[W-1];
  assign flag_z  = in_wb && (acc_reg == {W{1'b0}});

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed table-driven bench for mul_unit (W=32), plus
// hand-written sequences for start-while-busy and reset mid-RUN.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        accumulate;
  logic [31:0] rm_val, rs_val, rn_val;
  logic [3:0]  rd_addr;
  logic        stall, busy, done, wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flag_n, flag_z;

  int checks = 0;
  int errors = 0;

  mul_unit #(.W(32), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .rm_val(rm_val), .rs_val(rs_val), .rn_val(rn_val), .rd_addr(rd_addr),
    .stall(stall), .busy(busy), .done(done), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        acc;
    logic [31:0] rm, rs, rn;
    logic [3:0]  rd;
    logic [31:0] exp_data;
    logic        exp_we, exp_n, exp_z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] rs);
    int n;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (rs[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operation from IDLE and check latency, stall/busy and the
  // writeback. Inputs are scrambled after E0 to show they were captured.
  task automatic run_op(input vec_t v);
    int k;
    int stall_cycles;
    int busy_low;
    stall_cycles = 0;
    busy_low     = 0;
    accumulate = v.acc; rm_val = v.rm; rs_val = v.rs; rn_val = v.rn;
    rd_addr = v.rd; start = 1'b1;
    #1;
    if (stall) stall_cycles++;
    check("idle_busy", 32'(busy), 32'd0);
    next_cycle();  // E0
    start = 1'b0;
    accumulate = ~v.acc; rm_val = ~v.rm; rs_val = v.rs ^ 32'hA5A5_5A5A;
    rn_val = ~v.rn; rd_addr = ~v.rd;
    k = 0;
    while (!done && k < 100) begin
      if (stall) stall_cycles++;
      if (!busy) busy_low++;
      next_cycle();
      k++;
    end
    check("latency", 32'(k), 32'(exp_lat(v.rs)));
    check("stall_cycles", 32'(stall_cycles), 32'(1 + exp_lat(v.rs)));
    check("run_busy_low", 32'(busy_low), 32'd0);
    check("wb_done", 32'(done), 32'd1);
    check("wb_stall", 32'(stall), 32'd0);
    check("wb_busy", 32'(busy), 32'd1);
    check("wb_we", 32'(wb_we), 32'(v.exp_we));
    check("wb_addr", 32'(wb_addr), 32'(v.rd));
    check("wb_data", wb_data, v.exp_data);
    check("flag_n", 32'(flag_n), 32'(v.exp_n));
    check("flag_z", 32'(flag_z), 32'(v.exp_z));
    $display("op acc=%0d rm=%08h rs=%08h rn=%08h rd=%0d -> lat=%0d we=%0d data=%08h n=%0d z=%0d",
             v.acc, v.rm, v.rs, v.rn, v.rd, k, wb_we, wb_data, flag_n, flag_z);
    next_cycle();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_flags", 32'({flag_n, flag_z, wb_we}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_we"}, 32'(wb_we), 32'd0);
    check({tag, "_addr"}, 32'(wb_addr), 32'd0);
    check({tag, "_data"}, wb_data, 32'd0);
    check({tag, "_nz"}, 32'({flag_n, flag_z}), 32'd0);
  endtask

  initial begin
    int dones;
    int wes;
    //          acc   rm            rs            rn            rd     data          we    n     z
    vecs[0] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0,        4'd3,  32'h0000_002A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0005, 4'd1,  32'h0000_0003, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0,        4'd2,  32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF, 4'd4,  32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0009, 32'h0000_0000, 32'h0000_1234, 4'd5,  32'h0000_1234, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0,        4'd15, 32'h0000_0006, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0,        4'd7,  32'h2345_6780, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        4'd14, 32'h0000_0001, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; accumulate = 1'b0;
    rm_val = '0; rs_val = '0; rn_val = '0; rd_addr = '0;
    @(negedge clk);
    next_cycle();
    check_all_zero("reset");
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // A second start during RUN must be ignored: one done, no write (r15).
    accumulate = 1'b0; rm_val = 32'd2; rs_val = 32'd3; rn_val = '0;
    rd_addr = 4'd15; start = 1'b1;
    next_cycle();
    start = 1'b0;
    dones = 0; wes = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 1) begin
        start = 1'b1; rd_addr = 4'd6;
      end
      if (c == 2) start = 1'b0;
      if (done) dones++;
      if (wb_we) wes++;
      next_cycle();
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_we", 32'(wes), 32'd0);
    $display("start-while-busy: dones=%0d we=%0d", dones, wes);

    // Reset at RUN count=10 aborts the operation silently.
    accumulate = 1'b0; rm_val = 32'd5; rs_val = 32'hFFFF_FFFF; rd_addr = 4'd8;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 0; c < 10; c++) next_cycle();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    next_cycle();
    check_all_zero("abort");
    reset = 1'b0;
    dones = 0; wes = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      if (wb_we) wes++;
      next_cycle();
    end
    check("abort_dones", 32'(dones), 32'd0);
    check("abort_we", 32'(wes), 32'd0);
    $display("reset-abort: dones=%0d we=%0d", dones, wes);
    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multiply / multiply-accumulate unit for the ARM single-cycle core; executes MUL and MLA.
- Consumes register-file read data (Rm, Rs, Rn) and produces a writeback request (WE, address, data) for the register file write port.
- Asserts a stall while the iteration runs so the core holds the PC and the pipeline.
- Radix-2 shift-add datapath, one multiplier bit per clock.

Parameters:
- W, 32, operand and result width in bits
- CW, 6, iteration counter width; must satisfy 2^CW > W

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  issue request; sampled only in IDLE
- accumulate  input  1  1 = MLA (add rn_val), 0 = MUL
- rm_val  input  W  multiplicand (register-file RD1)
- rs_val  input  W  multiplier (register-file RD2)
- rn_val  input  W  accumulator operand; ignored when accumulate=0
- rd_addr  input  4  destination register index
- stall  output  1  holds the core; combinational
- busy  output  1  high in RUN and WB
- done  output  1  one-cycle completion pulse
- wb_we  output  1  register-file write enable
- wb_addr  output  4  register-file write address (A3)
- wb_data  output  W  register-file write data
- flag_n  output  1  result bit W-1; valid when done=1
- flag_z  output  1  result == 0; valid when done=1

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; wb_we=0, done=0, busy=0, wb_addr=0, wb_data=0, flag_n=0, flag_z=0; internal accumulator, multiplicand, multiplier and counter cleared.
- FSM states:
  - IDLE: on a rising edge E0 with start=1, capture rm_val into mcand, rs_val into mplier, rd_addr and accumulate. Initialise acc to rn_val if accumulate=1, else 0. Set count=0 and go to RUN. Otherwise remain in IDLE.
  - RUN: each edge, if mplier[0]=1 then acc <= acc + mcand (mod 2^W). Then mcand <= mcand<<1, mplier <= mplier>>1, count <= count+1. When count reaches W-1 at that edge, go to WB.
  - WB: lasts exactly one cycle. done=1; wb_we=1 (see the R15 rule below); wb_addr=captured rd; wb_data=acc; flags valid. Next edge: IDLE.
- Latency: WB begins exactly W edges after E0. It is not possible to issue back-to-back; the next start can be sampled on the edge that ends WB (WB→IDLE edge) only if it is still high in the following IDLE cycle. The earliest re-issue edge is therefore W+2 edges after E0.
- stall = (state==IDLE & start) | (state==RUN). It is low during WB, so the instruction retires in the WB cycle.
- busy = (state==RUN) | (state==WB).
- start while busy: ignored; no capture, no error.
- Result arithmetic: low W bits of rm*rs (+ rn). Overflow and carry are discarded. The unsigned and signed low halves are identical, so no sign handling is needed.
- Operands are captured at E0. Changes on rm_val, rs_val, rn_val or rd_addr after E0 have no effect.
- rd_addr==15 (PC destination, illegal for MUL): the full sequence runs and done pulses, but wb_we stays 0.
- Reset asserted mid-RUN or in WB: next edge forces the reset values. No writeback occurs and no done pulse is issued for the aborted operation.
- flag_n / flag_z: driven from the final acc during WB; held 0 outside WB.

Optional Feature:
- MUL_EARLY_TERM_EN defined: in RUN, leave for WB at the edge where the shifted multiplier becomes zero (mplier>>1 == 0) or count reaches W-1, whichever is first. WB then begins N = max(1, msb_index(rs)+1) edges after E0; rs=0 gives N=1. Results are identical to the full-length run.
- MUL_EARLY_TERM_EN undefined: always W iterations; fixed latency.

Test Plan:
- MUL, rm=0x00000007, rs=0x00000006, rd=3, W=32, no macro -> stall high for 33 cycles (start cycle + 32 RUN). WB begins 32 edges after E0 with wb_we=1, wb_addr=3, wb_data=0x0000002A, flag_z=0, flag_n=0.
- MLA, rm=0xFFFFFFFF, rs=0x00000002, rn=0x00000005, rd=1 -> wb_data=0x00000003 (wraps mod 2^32), flag_n=0.
- MUL, rm=0x80000000, rs=0x00000001 -> wb_data=0x80000000, flag_n=1. Also MUL with rs=0 -> wb_data=0, flag_z=1.
- rd=15, rm=2, rs=3 -> done pulses one cycle with wb_we=0. A second start pulse applied during RUN is ignored: exactly one done pulse is seen.
- Reset asserted at RUN count=10 -> next edge all outputs 0, state IDLE. No wb_we seen before a new start; a fresh start then completes normally.
- With MUL_EARLY_TERM_EN: rs=0x00000006 -> WB begins 3 edges after E0, wb_data correct. rs=0 -> WB begins 1 edge after E0 with wb_data=rn (MLA) or 0 (MUL).
